// File: rtl/vga_text_pkg.sv
// Shared geometry, character codes and controller state encoding for the text console.
package vga_text_pkg;

  // Default display geometry: 8x8 character cells.
  localparam int unsigned H_DISP     = 1280;
  localparam int unsigned V_DISP     = 1024;
  localparam int unsigned X_LIMIT    = H_DISP / 8;
  localparam int unsigned Y_LIMIT    = V_DISP / 8;
  localparam int unsigned ADDR_LIMIT = X_LIMIT * Y_LIMIT;
  localparam int unsigned ADDR_WIDTH = $clog2(ADDR_LIMIT);

  // Control characters recognised by the console.
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCROLL   = 2'd1,
    CLR_LINE = 2'd2,
    CLR_ALL  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/text_console_ctrl_fill_seq.sv
// Span filler: walks a run of consecutive text-buffer addresses, one per cycle.
// A go pulse takes priority over reset so the controller can restart a clear on
// the same edge that resets everything else.
module text_fill_seq #(
  parameter  int unsigned addr_width = 4,
  localparam int unsigned cnt_width  = addr_width + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go_i,
  input  logic [addr_width-1:0] start_i,
  input  logic [cnt_width-1:0]  len_i,
  output logic                  active_o,
  output logic [addr_width-1:0] addr_o,
  output logic                  done_o
);

  logic                  active_q;
  logic                  last_q;
  logic [addr_width-1:0] addr_q;
  logic [cnt_width-1:0]  rem_q;

  // Load a span on go, otherwise step the address and count down remaining cells.
  always_ff @(posedge clk) begin
    if (go_i) begin
      active_q <= (len_i != '0);
      addr_q   <= start_i;
      rem_q    <= len_i;
      last_q   <= (len_i == cnt_width'(1));
    end else if (reset) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      last_q   <= 1'b0;
    end else if (active_q) begin
      if (last_q) begin
        active_q <= 1'b0;
        last_q   <= 1'b0;
        rem_q    <= '0;
      end else begin
        addr_q <= addr_q + addr_width'(1);
        rem_q  <= rem_q - cnt_width'(1);
        last_q <= (rem_q == cnt_width'(2));
      end
    end
  end

  assign active_o = active_q;
  assign addr_o   = addr_q;
  assign done_o   = last_q;

endmodule

// File: rtl/text_console_ctrl.sv
// Text console sequencer: turns a valid/ready byte stream into text-buffer writes,
// tracks the cursor, and scrolls by rotating the ring-buffer origin.
module text_console_ctrl
  import vga_text_pkg::*;
#(
  parameter  int unsigned h_disp         = H_DISP,
  parameter  int unsigned v_disp         = V_DISP,
  parameter  bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned x_limit        = h_disp / 8,
  localparam int unsigned y_limit        = v_disp / 8,
  localparam int unsigned addr_limit     = x_limit * y_limit,
  localparam int unsigned addr_width     = $clog2(addr_limit),
  localparam int unsigned cx_width       = $clog2(x_limit),
  localparam int unsigned cy_width       = $clog2(y_limit)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_char,
  output logic                  in_ready,
  input  logic                  clear_req,
  output logic [addr_width-1:0] addr_init,
  output logic [addr_width-1:0] addr_write,
  output logic                  write_enable,
  output logic [7:0]            char_write,
  output logic [cx_width-1:0]   cursor_x,
  output logic [cy_width-1:0]   cursor_y,
  output logic                  busy
);

  localparam int unsigned                 cnt_width     = addr_width + 1;
  localparam logic [cx_width-1:0]         CX_LAST       = cx_width'(x_limit - 1);
  localparam logic [cy_width-1:0]         CY_LAST       = cy_width'(y_limit - 1);
  localparam logic [addr_width-1:0]       LAST_ROW_BASE = addr_width'((y_limit - 1) * x_limit);
  localparam logic [cnt_width-1:0]        ADDR_LIMIT_W  = cnt_width'(addr_limit);
  localparam logic [cnt_width-1:0]        X_LIMIT_W     = cnt_width'(x_limit);
  localparam ctrl_state_t                 RESET_STATE   = CLEAR_ON_RESET ? CLR_ALL : IDLE;

  ctrl_state_t           state_q, state_d;
  logic                  busy_q;
  logic [addr_width-1:0] addr_init_q, addr_init_d;
  logic [addr_width-1:0] addr_write_q, addr_write_d;
  logic                  we_q, we_d;
  logic [7:0]            char_q, char_d;
  logic [cx_width-1:0]   cx_q, cx_d;
  logic [cy_width-1:0]   cy_q, cy_d;

  logic                  in_ready_c;
  logic [addr_width-1:0] row_base_c;
  logic [cx_width-1:0]   cx_dec_c;
  logic [cnt_width-1:0]  scroll_sum_c;
  logic [addr_width-1:0] scroll_addr_c;

  logic                  fill_go_c;
  logic [addr_width-1:0] fill_start_c;
  logic [cnt_width-1:0]  fill_len_c;
  logic                  fill_active;
  logic [addr_width-1:0] fill_addr;
  logic                  fill_done;

  // Handshake and address arithmetic shared by the next-state logic.
  always_comb begin
    in_ready_c    = (state_q == IDLE) && !clear_req;
    row_base_c    = addr_width'(cy_q) * addr_width'(x_limit);
    cx_dec_c      = cx_q - cx_width'(1);
    scroll_sum_c  = {1'b0, addr_init_q} + X_LIMIT_W;
    scroll_addr_c = (scroll_sum_c >= ADDR_LIMIT_W) ? addr_width'(scroll_sum_c - ADDR_LIMIT_W)
                                                   : addr_width'(scroll_sum_c);
  end

  // Start the filler on the edge that enters CLR_ALL (reset or clear) or CLR_LINE (leaving SCROLL).
  always_comb begin
    if (reset) begin
      fill_go_c = CLEAR_ON_RESET;
    end else begin
      fill_go_c = ((state_q == IDLE) && clear_req) || (state_q == SCROLL);
    end
    if (!reset && (state_q == SCROLL)) begin
      fill_start_c = LAST_ROW_BASE;
      fill_len_c   = X_LIMIT_W;
    end else begin
      fill_start_c = '0;
      fill_len_c   = ADDR_LIMIT_W;
    end
  end

  text_fill_seq #(
    .addr_width(addr_width)
  ) u_fill (
    .clk      (clk),
    .reset    (reset),
    .go_i     (fill_go_c),
    .start_i  (fill_start_c),
    .len_i    (fill_len_c),
    .active_o (fill_active),
    .addr_o   (fill_addr),
    .done_o   (fill_done)
  );

  // Next-state, cursor and write-port decisions.
  always_comb begin
    state_d      = state_q;
    addr_init_d  = addr_init_q;
    addr_write_d = addr_write_q;
    we_d         = 1'b0;
    char_d       = char_q;
    cx_d         = cx_q;
    cy_d         = cy_q;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d     = CLR_ALL;
          addr_init_d = '0;
          cx_d        = '0;
          cy_d        = '0;
        end else if (in_valid) begin
          case (in_char)
            CHAR_LF: begin
              cx_d = '0;
              if (cy_q < CY_LAST) cy_d = cy_q + cy_width'(1);
              else                state_d = SCROLL;
            end
            CHAR_CR: begin
              cx_d = '0;
            end
            CHAR_BS: begin
              if (cx_q != '0) begin
                cx_d         = cx_dec_c;
                we_d         = 1'b1;
                addr_write_d = row_base_c + addr_width'(cx_dec_c);
                char_d       = CHAR_SPACE;
              end
            end
            default: begin
              we_d         = 1'b1;
              addr_write_d = row_base_c + addr_width'(cx_q);
              char_d       = in_char;
              if (cx_q < CX_LAST) begin
                cx_d = cx_q + cx_width'(1);
              end else begin
                cx_d = '0;
                if (cy_q < CY_LAST) cy_d = cy_q + cy_width'(1);
                else                state_d = SCROLL;
              end
            end
          endcase
        end
      end

      SCROLL: begin
        addr_init_d = scroll_addr_c;
        state_d     = CLR_LINE;
      end

      CLR_LINE, CLR_ALL: begin
        if (state_q == CLR_ALL) begin
          cx_d = '0;
          cy_d = '0;
        end
        if (fill_active) begin
          we_d         = 1'b1;
          addr_write_d = fill_addr;
          char_d       = CHAR_SPACE;
        end
        if (fill_done || !fill_active) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Controller state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      busy_q       <= (RESET_STATE != IDLE);
      addr_init_q  <= '0;
      addr_write_q <= '0;
      we_q         <= 1'b0;
      char_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != IDLE);
      addr_init_q  <= addr_init_d;
      addr_write_q <= addr_write_d;
      we_q         <= we_d;
      char_q       <= char_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  assign in_ready     = in_ready_c;
  assign addr_init    = addr_init_q;
  assign addr_write   = addr_write_q;
  assign write_enable = we_q;
  assign char_write   = char_q;
  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign busy         = busy_q;

endmodule
